// File: rtl/deframing_if.sv
// Bundles the serial input and the reassembled byte output of the deframer.
interface deframing_if;
  logic       din;
  logic       din_valid;
  logic [7:0] dout;
  logic       dout_valid;
  logic       frame_start;
  logic       frame_end;
  logic       frame_error;
  logic       in_frame;

  modport slave (
    input  din, din_valid,
    output dout, dout_valid, frame_start, frame_end, frame_error, in_frame
  );

  modport master (
    output din, din_valid,
    input  dout, dout_valid, frame_start, frame_end, frame_error, in_frame
  );
endinterface

// File: rtl/deframing.sv
// Serial deframer: hunts for a sync word in an LSB-first bit stream, then
// reassembles a fixed number of payload bytes with frame boundary flags.
module deframing #(
  parameter logic [7:0] SYNC_WORD     = 8'hA5,
  parameter int         PAYLOAD_BYTES = 4
) (
  input logic         clk,
  input logic         reset,
  deframing_if.slave  bus
);

  typedef enum logic {HUNT, PAYLOAD} state_t;

  localparam logic [7:0] LAST_BYTE = PAYLOAD_BYTES[7:0];

  state_t     state, state_nxt;
  logic [7:0] window, window_nxt;
  logic [3:0] fill, fill_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] byte_cnt, byte_cnt_nxt;
  logic [7:0] byte_sr, byte_sr_nxt;
  logic [7:0] dout_r, dout_nxt;
  logic       dout_valid_r, dout_valid_nxt;
  logic       frame_start_r, frame_start_nxt;
  logic       frame_end_r, frame_end_nxt;
  logic       frame_error_r, frame_error_nxt;

  logic [7:0] window_shift;
  logic [7:0] byte_shift;
  logic [7:0] byte_cnt_inc;

  assign window_shift = {bus.din, window[7:1]};
  assign byte_shift   = {bus.din, byte_sr[7:1]};
  assign byte_cnt_inc = byte_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= HUNT;
      window        <= '0;
      fill          <= '0;
      bit_cnt       <= '0;
      byte_cnt      <= '0;
      byte_sr       <= '0;
      dout_r        <= '0;
      dout_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_end_r   <= 1'b0;
      frame_error_r <= 1'b0;
    end else begin
      state         <= state_nxt;
      window        <= window_nxt;
      fill          <= fill_nxt;
      bit_cnt       <= bit_cnt_nxt;
      byte_cnt      <= byte_cnt_nxt;
      byte_sr       <= byte_sr_nxt;
      dout_r        <= dout_nxt;
      dout_valid_r  <= dout_valid_nxt;
      frame_start_r <= frame_start_nxt;
      frame_end_r   <= frame_end_nxt;
      frame_error_r <= frame_error_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    window_nxt      = window;
    fill_nxt        = fill;
    bit_cnt_nxt     = bit_cnt;
    byte_cnt_nxt    = byte_cnt;
    byte_sr_nxt     = byte_sr;
    dout_nxt        = dout_r;
    dout_valid_nxt  = 1'b0;
    frame_start_nxt = 1'b0;
    frame_end_nxt   = 1'b0;
    frame_error_nxt = 1'b0;

    unique case (state)
      HUNT: begin
        if (bus.din_valid) begin
          window_nxt = window_shift;
          if (fill != 4'd8) fill_nxt = fill + 4'd1;
          // fill counts bits before this one, so 7 means the current bit completes eight
          if (window_shift == SYNC_WORD && fill >= 4'd7) begin
            state_nxt       = PAYLOAD;
            frame_start_nxt = 1'b1;
            bit_cnt_nxt     = '0;
            byte_cnt_nxt    = '0;
          end
        end
      end

      PAYLOAD: begin
        if (bus.din_valid) begin
          byte_sr_nxt = byte_shift;
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            dout_nxt       = byte_shift;
            dout_valid_nxt = 1'b1;
            byte_cnt_nxt   = byte_cnt_inc;
            if (byte_cnt_inc == LAST_BYTE) begin
              frame_end_nxt = 1'b1;
              state_nxt     = HUNT;
              window_nxt    = '0;
              fill_nxt      = '0;
            end
          end
        end else if (bit_cnt != 3'd0) begin
          frame_error_nxt = 1'b1;
          state_nxt       = HUNT;
          window_nxt      = '0;
          fill_nxt        = '0;
          bit_cnt_nxt     = '0;
          byte_cnt_nxt    = '0;
        end
      end

      default: state_nxt = HUNT;
    endcase
  end

  assign bus.dout        = dout_r;
  assign bus.dout_valid  = dout_valid_r;
  assign bus.frame_start = frame_start_r;
  assign bus.frame_end   = frame_end_r;
  assign bus.frame_error = frame_error_r;
  assign bus.in_frame    = (state == PAYLOAD);

endmodule

// File: tb/tb_deframing.sv
// Drives directed and random serial streams into the deframer and compares
// every cycle against a queue-based model of the framing rules.
module tb_deframing;

  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int         NBYTES = 4;

  logic clk = 1'b0;
  logic reset;

  deframing_if bus();

  deframing #(.SYNC_WORD(SYNC), .PAYLOAD_BYTES(NBYTES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: hunt_q holds the most recent bits seen while hunting, pay_q the
  // bits of the byte under assembly; oldest bit sits at index 0.
  bit         hunt_q[$];
  bit         pay_q[$];
  bit         exp_in_frame = 1'b0;
  int         exp_bytes = 0;
  logic [7:0] exp_dout = '0;
  logic       exp_dv = 1'b0, exp_fs = 1'b0, exp_fe = 1'b0, exp_err = 1'b0;

  task automatic model_step(input logic r, input logic v, input logic b);
    int val;
    exp_dv  = 1'b0;
    exp_fs  = 1'b0;
    exp_fe  = 1'b0;
    exp_err = 1'b0;
    if (r) begin
      hunt_q.delete();
      pay_q.delete();
      exp_in_frame = 1'b0;
      exp_dout     = '0;
      exp_bytes    = 0;
    end else if (!exp_in_frame) begin
      if (v) begin
        hunt_q.push_back(b);
        if (hunt_q.size() > 8) void'(hunt_q.pop_front());
        if (hunt_q.size() == 8) begin
          val = 0;
          for (int i = 0; i < 8; i++) val = val + (int'(hunt_q[i]) << i);
          if (val == int'(SYNC)) begin
            exp_in_frame = 1'b1;
            exp_fs       = 1'b1;
            exp_bytes    = 0;
            pay_q.delete();
          end
        end
      end
    end else begin
      if (v) begin
        pay_q.push_back(b);
        if (pay_q.size() == 8) begin
          val = 0;
          for (int i = 0; i < 8; i++) val = val + (int'(pay_q[i]) << i);
          exp_dout = val[7:0];
          exp_dv   = 1'b1;
          exp_bytes++;
          pay_q.delete();
          if (exp_bytes == NBYTES) begin
            exp_fe       = 1'b1;
            exp_in_frame = 1'b0;
            hunt_q.delete();
          end
        end
      end else if (pay_q.size() != 0) begin
        exp_err      = 1'b1;
        exp_in_frame = 1'b0;
        hunt_q.delete();
        pay_q.delete();
      end
    end
  endtask

  task automatic check_sig(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_output();
    check_sig("dout",        bus.dout,                 exp_dout);
    check_sig("dout_valid",  {7'b0, bus.dout_valid},   {7'b0, exp_dv});
    check_sig("frame_start", {7'b0, bus.frame_start},  {7'b0, exp_fs});
    check_sig("frame_end",   {7'b0, bus.frame_end},    {7'b0, exp_fe});
    check_sig("frame_error", {7'b0, bus.frame_error},  {7'b0, exp_err});
    check_sig("in_frame",    {7'b0, bus.in_frame},     {7'b0, exp_in_frame});
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are checked there too.
  task automatic apply_stimulus(input logic r, input logic v, input logic b);
    reset         = r;
    bus.din_valid = v;
    bus.din       = b;
    @(posedge clk);
    model_step(r, v, b);
    #1;
    check_output();
  endtask

  task automatic send_bits(input logic [7:0] value, input int count);
    for (int i = 0; i < count; i++) apply_stimulus(1'b0, 1'b1, value[i]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 1'b0, 1'($urandom));
  endtask

  task automatic send_frame(input logic [31:0] payload, input int gap);
    send_bits(SYNC, 8);
    for (int k = 0; k < NBYTES; k++) begin
      send_bits(payload[8*k +: 8], 8);
      if (gap > 0) idle(gap);
    end
  endtask

  initial begin
    logic [31:0] word;
    int          junk;

    // Reset held with a busy input stream
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b1, 1'(i));

    // Basic contiguous frame
    send_frame(32'h44332211, 0);
    idle(2);

    // Idle gaps on byte boundaries only
    send_frame(32'h44332211, 5);
    idle(2);

    // Gap after three bits of the second byte aborts, then a clean frame
    send_bits(SYNC, 8);
    send_bits(8'h11, 8);
    send_bits(8'h22, 3);
    apply_stimulus(1'b0, 1'b0, 1'b0);
    idle(2);
    send_frame(32'h88776655, 0);

    // Junk bits shift the sync offset; payload carries the sync pattern as data
    apply_stimulus(1'b0, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b1);
    send_frame(32'h44A5A511, 0);
    send_frame(32'hA5A5A5A5, 0);
    idle(3);

    // Reset in the middle of a frame, then a new frame
    send_bits(SYNC, 8);
    send_bits(8'h11, 8);
    send_bits(8'h22, 8);
    send_bits(8'h33, 3);
    apply_stimulus(1'b1, 1'b1, 1'b1);
    send_frame(32'hDEADBEEF, 0);
    idle(2);

    // Random frames with random junk, boundary gaps and occasional aborts
    for (int n = 0; n < 40; n++) begin
      junk = int'($urandom_range(0, 10));
      for (int i = 0; i < junk; i++) apply_stimulus(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom));
      word = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        send_bits(SYNC, 8);
        send_bits(word[7:0], int'($urandom_range(1, 7)));
        idle(1);
      end else begin
        send_frame(word, int'($urandom_range(0, 3)));
      end
    end

    // Fully random stream
    for (int i = 0; i < 400; i++) apply_stimulus(1'b0, 1'($urandom_range(0, 7) != 0), 1'($urandom));

    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/deframing.md
Name: deframing

Overview:
- Receive-side stage directly downstream of the byte serializer in the framing_encoding path.
- Consumes the serial bit stream (bit + valid) and hunts for an 8-bit sync word.
- After sync, reassembles a fixed number of payload bytes and emits them in parallel with frame-boundary and error flags.
- Its output feeds the byte-level decoder.

Parameters:
SYNC_WORD, 8'hA5, 8-bit pattern marking frame start; first-received bit is bit 0.
PAYLOAD_BYTES, 4, payload bytes per frame after the sync word; legal range 1..255.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
din  input  1  serial data bit, LSB of each byte first.
din_valid  input  1  din is a valid bit this cycle.
dout  output  8  reassembled payload byte.
dout_valid  output  1  one-cycle strobe; dout holds a new payload byte.
frame_start  output  1  one-cycle pulse; sync word just detected.
frame_end  output  1  asserted together with dout_valid on the last payload byte of a frame.
frame_error  output  1  one-cycle pulse; frame aborted by a mid-byte gap.
in_frame  output  1  high while in state PAYLOAD.

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high. The rest of the codebase uses clk/reset_n naming, but this block's reset polarity and synchronicity are fixed as active-high synchronous.
- Reset values: dout=0, dout_valid=0, frame_start=0, frame_end=0, frame_error=0, in_frame=0, state=HUNT, window=0, fill=0, bit_cnt=0, byte_cnt=0.
  - reset wins over every other event in the same cycle. A frame in progress is dropped with no frame_error.
- Bit shifting: a bit is consumed only on cycles with din_valid=1. Shift rule: shreg <= {din, shreg[7:1]}. After 8 valid bits, shreg[0] is the first bit received.
- State HUNT:
  - Each valid bit shifts into window; fill counts 0..8 and saturates at 8.
  - Match condition: the post-shift window equals SYNC_WORD and at least 8 bits have been collected, including the current bit.
  - On match: go to PAYLOAD, pulse frame_start next cycle, clear bit_cnt and byte_cnt.
  - Gaps (din_valid=0) in HUNT are ignored; the window is retained.
- State PAYLOAD:
  - Each valid bit shifts into the byte register and increments bit_cnt (3-bit, wraps 7->0).
  - On the 8th bit (bit_cnt==7 with din_valid=1): register dout=assembled byte and pulse dout_valid for exactly one cycle after that edge (latency 1 cycle from 8th bit sample). Then increment byte_cnt.
  - If that byte is number PAYLOAD_BYTES: assert frame_end in the same cycle as its dout_valid, return to HUNT, and clear window and fill to 0.
  - Gaps with bit_cnt==0 (byte boundary) are legal and unbounded; state is held.
  - din_valid=0 with bit_cnt!=0: abort. Pulse frame_error for one cycle, discard the partial byte, go to HUNT, clear window/fill/bit_cnt/byte_cnt. No dout_valid is issued for the partial byte.
  - Sync-word bit patterns inside the payload are treated as data. No re-sync occurs while in PAYLOAD.
- Outputs:
  - dout holds its last value between strobes.
  - in_frame is the registered state (1 in PAYLOAD).
  - Back-to-back frames: the sync word may begin on the cycle immediately after the last payload bit. The window starts empty, so detection needs a full 8 new bits.
- Widths: byte_cnt is 8 bits; the compare against PAYLOAD_BYTES is exact. No overflow is possible for legal PAYLOAD_BYTES.

Test Plan:
- Reset: hold reset 3 cycles with din_valid=1, din toggling -> all outputs 0, no frame_start.
- Basic frame: defaults; send A5 then 11,22,33,44 LSB-first, contiguous -> frame_start 1 cycle after the 8th sync bit. Four dout_valid strobes with dout=11,22,33,44, each 1 cycle after that byte's 8th bit; frame_end only with 44; in_frame drops the cycle after.
- Byte-boundary gaps: same frame with 5 idle cycles (din_valid=0) between bytes -> identical bytes, no frame_error.
- Mid-byte gap: after sync and byte 11, send 3 bits of 22, drop din_valid 1 cycle -> frame_error pulse, no further dout_valid. A following A5,55,66,77,88 frame is received cleanly.
- Sliding sync and payload: junk bits 0,1,1 then A5 -> sync found at the correct bit offset. A payload containing A5 is output as data; frame_end still falls on the 4th byte.
- Reset mid-frame: assert reset after 2 payload bytes -> outputs cleared next cycle, no frame_error. A new frame after reset is received correctly.
